// File: rtl/clk_switch_ctrl_if.sv
// Request/status bundle between a switch requester and clk_switch_ctrl.
// The requester drives the request pair; the controller drives select and status.
interface clk_switch_ctrl_if;
    logic i_req;
    logic i_req_sel;
    logic o_sel;
    logic o_busy;
    logic o_ack;
    logic o_err;
    logic o_clk1_alive;

    modport master (
        output i_req,
        output i_req_sel,
        input  o_sel,
        input  o_busy,
        input  o_ack,
        input  o_err,
        input  o_clk1_alive
    );

    modport slave (
        input  i_req,
        input  i_req_sel,
        output o_sel,
        output o_busy,
        output o_ack,
        output o_err,
        output o_clk1_alive
    );
endinterface

// File: rtl/clk_switch_ctrl.sv
// Sequencer for the glitch-free two-clock mux select: verifies i_clk1 activity,
// holds a settle window after each select change, and falls back to i_clk0 on loss.
module clk_switch_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned CNT_W         = 8,
    parameter bit          FALLBACK      = 1'b1
) (
    input  logic              i_clk0,
    input  logic              i_rstn,
    input  logic              i_clk1,
    clk_switch_ctrl_if.slave  bus
);

    localparam int unsigned ACT_W = 3;
    localparam int unsigned EVT_W = 2;
    localparam logic [CNT_W-1:0] TO_CNT     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SWITCH,
        S_DONE,
        S_FAIL
    } state_e;

    // i_clk1 domain: free-running activity counter, MSB is the only crossing signal
    logic [ACT_W-1:0] act_cnt_q;
    logic [ACT_W-1:0] act_cnt_d;

    always_comb begin
        act_cnt_d = act_cnt_q + ACT_W'(1);
    end

    always_ff @(posedge i_clk1 or negedge i_rstn) begin
        if (!i_rstn) act_cnt_q <= '0;
        else         act_cnt_q <= act_cnt_d;
    end

    // i_clk0 domain state
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             edge_q,  edge_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             seen_q,  seen_d;
    logic             alive_q, alive_d;
    state_e           state_q, state_d;
    logic             tgt_q,   tgt_d;
    logic             fb_q,    fb_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             sel_q,   sel_d;
    logic             busy_q,  busy_d;
    logic             ack_q,   ack_d;
    logic             err_q,   err_d;
    logic             act_evt_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Synchronizer, edge detect and liveness watchdog
    always_comb begin
        sync1_d   = act_cnt_q[ACT_W-1];
        sync2_d   = sync1_q;
        edge_d    = sync2_q;
        act_evt_c = sync2_q ^ edge_q;
        wd_cnt_d  = wd_cnt_q;
        seen_d    = seen_q;
        if (act_evt_c) begin
            wd_cnt_d = '0;
            seen_d   = 1'b1;
        end else if (wd_cnt_q < TO_CNT) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
        alive_d = seen_d && (wd_cnt_d < TO_CNT);
    end

    // Sequencer next-state and registered outputs
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        fb_d      = fb_q;
        cnt_d     = cnt_q;
        evt_cnt_d = evt_cnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = err_q;
        cnt_inc_c = cnt_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    // ack cycle of the previous sequence; busy drops with ack
                    busy_d = 1'b0;
                end else if (FALLBACK && sel_q && !alive_q) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b1;
                    tgt_d   = 1'b0;
                    fb_d    = 1'b1;
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SWITCH;
                end else if (bus.i_req) begin
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    tgt_d  = bus.i_req_sel;
                    fb_d   = 1'b0;
                    if (bus.i_req_sel == sel_q) begin
                        state_d = S_DONE;
                    end else if (!bus.i_req_sel) begin
                        sel_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_SWITCH;
                    end else begin
                        cnt_d     = '0;
                        evt_cnt_d = '0;
                        state_d   = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                cnt_d = cnt_inc_c;
                if (act_evt_c) evt_cnt_d = evt_cnt_q + EVT_W'(1);
                if (act_evt_c && (evt_cnt_q == EVT_W'(1))) begin
                    sel_d   = tgt_q;
                    cnt_d   = '0;
                    state_d = S_SWITCH;
                end else if (cnt_inc_c == TO_CNT) begin
                    state_d = S_FAIL;
                end
            end
            S_SWITCH: begin
                cnt_d = cnt_inc_c;
                if (cnt_inc_c == SETTLE_CNT) begin
                    if (fb_q) begin
                        // fallback completes silently
                        fb_d    = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk0 or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            edge_q    <= 1'b0;
            wd_cnt_q  <= '0;
            seen_q    <= 1'b0;
            alive_q   <= 1'b0;
            state_q   <= S_IDLE;
            tgt_q     <= 1'b0;
            fb_q      <= 1'b0;
            cnt_q     <= '0;
            evt_cnt_q <= '0;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            edge_q    <= edge_d;
            wd_cnt_q  <= wd_cnt_d;
            seen_q    <= seen_d;
            alive_q   <= alive_d;
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            fb_q      <= fb_d;
            cnt_q     <= cnt_d;
            evt_cnt_q <= evt_cnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_sel        = sel_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_ack        = ack_q;
    assign bus.o_err        = err_q;
    assign bus.o_clk1_alive = alive_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: directed scenarios plus a randomized
// request stream checked against a transaction-level timing model.
module tb_clk_switch_ctrl;

    localparam int SETTLE   = 16;
    localparam int TOUT     = 64;
    localparam int HALF0    = 50;
    localparam int WIN      = 120;

    logic i_clk0 = 1'b0;
    logic i_clk1 = 1'b0;
    logic i_rstn = 1'b0;
    bit   clk1_run = 1'b0;
    int   clk1_half = 100;
    int   clk1_edges = 0;
    int   errors = 0;
    int   checks = 0;

    clk_switch_ctrl_if ifc ();

    clk_switch_ctrl dut (
        .i_clk0 (i_clk0),
        .i_rstn (i_rstn),
        .i_clk1 (i_clk1),
        .bus    (ifc)
    );

    always #(HALF0) i_clk0 = ~i_clk0;

    // clk1 stops low immediately when disabled: no trailing edge after the stop
    always begin
        #(clk1_half);
        if (clk1_run) i_clk1 = ~i_clk1;
        else          i_clk1 = 1'b0;
    end

    always @(posedge i_clk1) clk1_edges <= clk1_edges + 1;

    initial begin
        #(5_000_000);
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "global timeout");
    end

    // Reference timing: sample index (edges after E0) where ack is expected
    function automatic int exp_ack_at(input bit same, input bit fail, input int chg_at);
        if (same)      return 1;
        else if (fail) return TOUT + 1;
        else           return chg_at + SETTLE + 1;
    endfunction

    // One request: waits for idle, issues it at E0, records outcome over a fixed window
    task automatic run_txn(input bit tgt, input int pulse_at, output int chg_at, output int ack_at,
                           output int ack_n, output bit err_ack, output int busy_lo, output bit sel_end);
        bit sel0;
        int w;
        w = 0;
        while (ifc.o_busy !== 1'b0 && w < 200) begin
            @(negedge i_clk0);
            w++;
        end
        if (w >= 200) begin
            checks++; errors++;
            $display("FAIL idle_wait busy got=%b exp=0", ifc.o_busy);
        end
        sel0 = ifc.o_sel;
        ifc.i_req = 1'b1;
        ifc.i_req_sel = tgt;
        chg_at = -1; ack_at = -1; ack_n = 0; err_ack = 1'b0; busy_lo = -1;
        for (int j = 0; j < WIN; j++) begin
            @(negedge i_clk0);
            if (chg_at < 0 && ifc.o_sel !== sel0) chg_at = j;
            if (ifc.o_ack === 1'b1) begin
                if (ack_n == 0) begin
                    ack_at = j;
                    err_ack = ifc.o_err;
                end
                ack_n++;
            end
            if (busy_lo < 0 && ifc.o_busy === 1'b0) busy_lo = j;
            if (pulse_at > 0 && chg_at >= 0 && j == chg_at + pulse_at) begin
                ifc.i_req = 1'b1;
                ifc.i_req_sel = 1'b0;
            end else begin
                ifc.i_req = 1'b0;
            end
        end
        sel_end = ifc.o_sel;
    endtask

    task automatic test_reset();
        int n;
        checks++; if (ifc.o_sel !== 1'b0)  begin errors++; $display("FAIL reset_sel got=%b exp=0", ifc.o_sel); end
        checks++; if (ifc.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", ifc.o_busy); end
        checks++; if (ifc.o_ack !== 1'b0)  begin errors++; $display("FAIL reset_ack got=%b exp=0", ifc.o_ack); end
        checks++; if (ifc.o_err !== 1'b0)  begin errors++; $display("FAIL reset_err got=%b exp=0", ifc.o_err); end
        checks++; if (ifc.o_clk1_alive !== 1'b0) begin errors++; $display("FAIL reset_alive got=%b exp=0", ifc.o_clk1_alive); end
        clk1_half = 100;
        clk1_run = 1'b1;
        n = 0;
        while (ifc.o_clk1_alive !== 1'b1 && n < 40) begin
            @(negedge i_clk0);
            n++;
        end
        checks++; if (ifc.o_clk1_alive !== 1'b1) begin errors++; $display("FAIL alive_rise got=%b exp=1 after %0d cycles", ifc.o_clk1_alive, n); end
    endtask

    task automatic test_same(input bit tgt);
        int c, a, an, bl; bit e, s;
        run_txn(tgt, 0, c, a, an, e, bl, s);
        checks++; if (a !== exp_ack_at(1'b1, 1'b0, 0)) begin errors++; $display("FAIL same_ack_at got=%0d exp=%0d", a, exp_ack_at(1'b1, 1'b0, 0)); end
        checks++; if (an !== 1) begin errors++; $display("FAIL same_ack_n got=%0d exp=1", an); end
        checks++; if (c !== -1) begin errors++; $display("FAIL same_sel_toggle got=%0d exp=-1", c); end
        checks++; if (bl !== 2) begin errors++; $display("FAIL same_busy_len got=%0d exp=2", bl); end
        checks++; if (s !== tgt) begin errors++; $display("FAIL same_sel got=%b exp=%b", s, tgt); end
    endtask

    task automatic test_nominal(input int rise_max);
        int c, a, an, bl; bit e, s;
        run_txn(1'b1, 0, c, a, an, e, bl, s);
        checks++; if (c < 1 || c > rise_max) begin errors++; $display("FAIL nom_rise got=%0d exp=1..%0d", c, rise_max); end
        checks++; if (a !== exp_ack_at(1'b0, 1'b0, c)) begin errors++; $display("FAIL nom_ack_at got=%0d exp=%0d", a, exp_ack_at(1'b0, 1'b0, c)); end
        checks++; if (an !== 1) begin errors++; $display("FAIL nom_ack_n got=%0d exp=1", an); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL nom_err got=%b exp=0", e); end
        checks++; if (bl !== a + 1) begin errors++; $display("FAIL nom_busy_lo got=%0d exp=%0d", bl, a + 1); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL nom_sel got=%b exp=1", s); end
    endtask

    task automatic test_to_clk0();
        int c, a, an, bl; bit e, s;
        run_txn(1'b0, 0, c, a, an, e, bl, s);
        checks++; if (c !== 0) begin errors++; $display("FAIL to0_sel_at got=%0d exp=0", c); end
        checks++; if (a !== exp_ack_at(1'b0, 1'b0, 0)) begin errors++; $display("FAIL to0_ack_at got=%0d exp=%0d", a, exp_ack_at(1'b0, 1'b0, 0)); end
        checks++; if (bl !== SETTLE + 2) begin errors++; $display("FAIL to0_busy_lo got=%0d exp=%0d", bl, SETTLE + 2); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL to0_sel got=%b exp=0", s); end
    endtask

    task automatic test_dead();
        int c, a, an, bl; bit e, s;
        clk1_run = 1'b0;
        repeat (10) @(negedge i_clk0);
        run_txn(1'b1, 0, c, a, an, e, bl, s);
        checks++; if (a !== exp_ack_at(1'b0, 1'b1, 0)) begin errors++; $display("FAIL dead_ack_at got=%0d exp=%0d", a, exp_ack_at(1'b0, 1'b1, 0)); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL dead_err got=%b exp=1", e); end
        checks++; if (c !== -1) begin errors++; $display("FAIL dead_sel_toggle got=%0d exp=-1", c); end
        checks++; if (bl !== TOUT + 2) begin errors++; $display("FAIL dead_busy_lo got=%0d exp=%0d", bl, TOUT + 2); end
        checks++; if (ifc.o_err !== 1'b1) begin errors++; $display("FAIL dead_err_sticky got=%b exp=1", ifc.o_err); end
        clk1_run = 1'b1;
    endtask

    task automatic test_fallback();
        int n, busy_n, ack_seen;
        clk1_half = 100;
        test_nominal(30);
        repeat (5) @(negedge i_clk0);
        checks++; if (ifc.o_clk1_alive !== 1'b1) begin errors++; $display("FAIL fb_alive_pre got=%b exp=1", ifc.o_clk1_alive); end
        clk1_run = 1'b0;
        n = 0;
        ack_seen = 0;
        while (ifc.o_clk1_alive !== 1'b0 && n < 100) begin
            @(negedge i_clk0);
            n++;
        end
        checks++; if (n < 50 || n > TOUT + 3) begin errors++; $display("FAIL fb_alive_fall got=%0d exp=50..%0d", n, TOUT + 3); end
        @(negedge i_clk0);
        checks++; if (ifc.o_sel !== 1'b0) begin errors++; $display("FAIL fb_sel got=%b exp=0", ifc.o_sel); end
        checks++; if (ifc.o_err !== 1'b1) begin errors++; $display("FAIL fb_err got=%b exp=1", ifc.o_err); end
        busy_n = (ifc.o_busy === 1'b1) ? 1 : 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge i_clk0);
            if (ifc.o_busy === 1'b1) busy_n++;
            if (ifc.o_ack === 1'b1) ack_seen++;
        end
        checks++; if (busy_n !== SETTLE) begin errors++; $display("FAIL fb_busy_len got=%0d exp=%0d", busy_n, SETTLE); end
        checks++; if (ack_seen !== 0) begin errors++; $display("FAIL fb_no_ack got=%0d exp=0", ack_seen); end
        clk1_run = 1'b1;
    endtask

    task automatic test_collision();
        int c, a, an, bl; bit e, s;
        repeat (20) @(negedge i_clk0);
        run_txn(1'b1, 5, c, a, an, e, bl, s);
        checks++; if (a !== exp_ack_at(1'b0, 1'b0, c)) begin errors++; $display("FAIL coll_ack_at got=%0d exp=%0d", a, exp_ack_at(1'b0, 1'b0, c)); end
        checks++; if (an !== 1) begin errors++; $display("FAIL coll_ack_n got=%0d exp=1", an); end
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL coll_sel got=%b exp=1", s); end
    endtask

    task automatic test_reset_mid();
        ifc.i_req = 1'b1;
        ifc.i_req_sel = 1'b0;
        @(negedge i_clk0);
        ifc.i_req = 1'b0;
        repeat (4) @(negedge i_clk0);
        checks++; if (ifc.o_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got=%b exp=1", ifc.o_busy); end
        #10 i_rstn = 1'b0;
        #1;
        checks++; if ({ifc.o_sel, ifc.o_busy, ifc.o_ack, ifc.o_err, ifc.o_clk1_alive} !== 5'b0) begin
            errors++;
            $display("FAIL rmid_outs got=%b exp=00000", {ifc.o_sel, ifc.o_busy, ifc.o_ack, ifc.o_err, ifc.o_clk1_alive});
        end
        @(negedge i_clk0);
        i_rstn = 1'b1;
        @(negedge i_clk0);
        test_nominal(30);
    endtask

    task automatic test_ratio_sweep();
        int halves [3] = '{500, 50, 17};
        int base, n;
        for (int r = 0; r < 3; r++) begin
            clk1_run = 1'b0;
            repeat (3) @(negedge i_clk0);
            i_rstn = 1'b0;
            repeat (2) @(negedge i_clk0);
            i_rstn = 1'b1;
            clk1_half = halves[r];
            base = clk1_edges;
            clk1_run = 1'b1;
            // slow clk1: launch just before the 4th edge so two events fit the window
            n = 0;
            while ((clk1_edges - base) < 3 && n < 200) begin
                @(negedge i_clk0);
                n++;
            end
            checks++; if ((clk1_edges - base) < 3) begin errors++; $display("FAIL ratio_clk1_edges got=%0d exp>=3", clk1_edges - base); end
            test_nominal(TOUT);
        end
    endtask

    task automatic test_random();
        bit exp_sel;
        bit tgt;
        int c, a, an, bl; bit e, s;
        exp_sel = 1'b1;
        for (int i = 0; i < 14; i++) begin
            clk1_half = $urandom_range(20, 110);
            tgt = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge i_clk0);
            run_txn(tgt, 0, c, a, an, e, bl, s);
            if (tgt == exp_sel) begin
                checks++; if (a !== exp_ack_at(1'b1, 1'b0, 0) || c !== -1) begin errors++; $display("FAIL rnd%0d_same ack_at=%0d chg=%0d exp=1,-1", i, a, c); end
            end else if (tgt == 1'b0) begin
                checks++; if (c !== 0 || a !== exp_ack_at(1'b0, 1'b0, 0)) begin errors++; $display("FAIL rnd%0d_to0 chg=%0d ack_at=%0d exp=0,%0d", i, c, a, SETTLE + 1); end
            end else begin
                checks++; if (c < 1 || c > TOUT || a !== exp_ack_at(1'b0, 1'b0, c)) begin errors++; $display("FAIL rnd%0d_to1 chg=%0d ack_at=%0d exp=1..%0d,chg+%0d", i, c, a, TOUT, SETTLE + 1); end
            end
            exp_sel = tgt;
            checks++; if (an !== 1 || e !== 1'b0 || bl !== a + 1) begin errors++; $display("FAIL rnd%0d_status ack_n=%0d err=%b busy_lo=%0d exp=1,0,%0d", i, an, e, bl, a + 1); end
            checks++; if (s !== exp_sel) begin errors++; $display("FAIL rnd%0d_sel got=%b exp=%b", i, s, exp_sel); end
        end
    endtask

    initial begin
        ifc.i_req = 1'b0;
        ifc.i_req_sel = 1'b0;
        i_rstn = 1'b0;
        repeat (3) @(negedge i_clk0);
        i_rstn = 1'b1;
        @(negedge i_clk0);
        test_reset();
        test_same(1'b0);
        test_nominal(30);
        test_same(1'b1);
        test_to_clk0();
        test_dead();
        test_fallback();
        test_collision();
        test_reset_mid();
        test_ratio_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
